// File: rtl/fpu_pkg.sv
// Shared fp32 types and helpers for the FPU issue/collect logic.
package fpu_pkg;

    localparam int unsigned FADD_LAT = 3;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Sign flip only; NaN payloads and zeros pass through with the sign inverted.
    function automatic fp32_t fneg(input fp32_t a);
        fp32_t r;
        r      = a;
        r.sign = ~a.sign;
        return r;
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with a registered head word and registered full/empty.
// No bypass: a write into an empty FIFO becomes visible on the following cycle.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     head_nxt;
    logic             do_rd;

    // Next pointers, count and head word.
    always_comb begin
        do_rd      = rd_en & ~empty;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        head_nxt   = rd_data;
        if (wr_en) begin
            wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
        case ({wr_en, do_rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
        // The head register tracks the oldest entry; the storage array keeps a copy of every entry.
        if (do_rd && (cnt > ONE_CNT)) begin
            head_nxt = mem[rd_ptr_nxt];
        end else if (wr_en && (empty || do_rd)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            cnt     <= cnt_nxt;
            rd_data <= head_nxt;
            full    <= (cnt_nxt == FULL_CNT);
            empty   <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Issue/collect wrapper around a fixed-latency pipelined fp32 adder: registers operands,
// tracks valid+tag beside the adder pipe, and buffers results behind a credit counter.
module fadd_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned FADD_LAT = fpu_pkg::FADD_LAT,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fadd_x1,
    output logic [31:0]      fadd_x2,
    input  logic [31:0]      fadd_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned L     = FADD_LAT + 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned W     = 32 + TAG_W;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic             accept_c;
    logic             pop_c;
    fp32_t            x2_c;
    logic [L-1:0]     vld;
    logic [TAG_W-1:0] tag_pipe [L];
    logic [OCC_W-1:0] occ, occ_nxt;
    logic [W-1:0]     head;
    logic             fifo_full;
    logic             fifo_empty;

    assign accept_c = in_valid & in_ready;
    assign pop_c    = out_valid & out_ready;

    always_comb begin
        x2_c = in_sub ? fneg(fp32_t'(in_rs2)) : fp32_t'(in_rs2);
    end

    // Operand registers feeding the adder; they hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fadd_x1 <= '0;
            fadd_x2 <= '0;
        end else if (accept_c) begin
            fadd_x1 <= in_rs1;
            fadd_x2 <= 32'(x2_c);
        end
    end

    // Valid/tag shadow of the adder pipe; the last stage lines up with fadd_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < int'(L); i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            vld         <= {vld[L-2:0], accept_c};
            tag_pipe[0] <= in_tag;
            for (int i = 1; i < int'(L); i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Credits cover ops in the pipe plus ops waiting in the FIFO.
    always_comb begin
        case ({accept_c, pop_c})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            occ      <= occ_nxt;
            in_ready <= (occ_nxt < OCC_MAX);
            busy     <= (occ_nxt != '0);
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld[L-1]),
        .wr_data ({fadd_y, tag_pipe[L-1]}),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = ~fifo_empty;
    assign out_result = head[W-1:TAG_W];
    assign out_tag    = head[TAG_W-1:0];

    // Credits guarantee room; a write into a full FIFO means the accounting is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(vld[L-1] && fifo_full));

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Self-checking bench for fadd_issue_ctrl with a behavioural 3-stage fp32 adder stand-in.
module tb_fadd_issue_ctrl;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned DEPTH = 4;
    localparam int          LAT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sub;
    logic [31:0]      in_rs1, in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fadd_x1, fadd_x2, fadd_y;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];
    int          acc_q[$];
    logic [31:0] cur_exp;

    always #5 clk = ~clk;

    fadd_issue_ctrl #(.FADD_LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    function automatic logic [31:0] to_fp32(input real r);
        logic [63:0] b;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    function automatic real from_fp32(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'h0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    // Adder stand-in: x sampled on one edge, y updated LAT edges later counting that edge.
    logic [31:0] fa_s0, fa_s1;
    always @(posedge clk) begin
        fa_s0  <= to_fp32(from_fp32(fadd_x1) + from_fp32(fadd_x2));
        fa_s1  <= fa_s0;
        fadd_y <= fa_s1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge, logging accepted ops and popped results around it.
    task automatic tick();
        if (in_valid && in_ready) begin
            exp_q.push_back({cur_exp, in_tag});
            acc_q.push_back(cycle + 1);
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({out_result, out_tag});
            if (acc_q.size() > 0) void'(acc_q.pop_front());
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic set_op(input int a, input int b, input bit sub, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_rs1   = to_fp32(real'(a));
        in_rs2   = to_fp32(real'(b));
        in_sub   = sub;
        in_tag   = tag;
        cur_exp  = to_fp32(sub ? (real'(a) - real'(b)) : (real'(a) + real'(b)));
    endtask

    task automatic set_rand_op(input logic [TAG_W-1:0] tag);
        set_op(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
               bit'($urandom_range(0, 1)), tag);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && acc_q.size() > 0; i++) tick();
        n_tests++;
        if (acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d ops still in flight, expected 0", acc_q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sub = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0; cur_exp = '0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (fadd_x1 !== 32'h0) begin n_fail++; $display("FAIL reset_x1: got %h expected 0", fadd_x1); end
        n_tests++; if (fadd_x2 !== 32'h0) begin n_fail++; $display("FAIL reset_x2: got %h expected 0", fadd_x2); end
        n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", out_result); end
        n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
        rst = 1'b0;
        tick();
        acc_q.delete();
        clear_sb();
    endtask

    task automatic test_add();
        clear_sb();
        set_op(1, 2, 1'b0, 5'd3);
        tick();
        in_valid = 1'b0;
        n_tests++; if (fadd_x1 !== 32'h3F800000) begin n_fail++; $display("FAIL add_x1: got %h expected 3f800000", fadd_x1); end
        n_tests++; if (fadd_x2 !== 32'h40000000) begin n_fail++; $display("FAIL add_x2: got %h expected 40000000", fadd_x2); end
        repeat (3) tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b expected 0 after 4 edges", out_valid); end
        n_tests++; if (fadd_x1 !== 32'h3F800000) begin n_fail++; $display("FAIL add_x1_hold: got %h expected 3f800000", fadd_x1); end
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1 after 5 edges", out_valid); end
        n_tests++; if (out_result !== 32'h40400000) begin n_fail++; $display("FAIL add_result: got %h expected 40400000", out_result); end
        n_tests++; if (out_tag !== 5'd3) begin n_fail++; $display("FAIL add_tag: got %0d expected 3", out_tag); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b expected 1", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_pop_valid: got %b expected 0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_pop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_sub();
        clear_sb();
        set_op(3, 1, 1'b1, 5'd5);
        tick();
        in_valid = 1'b0;
        n_tests++; if (fadd_x2 !== 32'hBF800000) begin n_fail++; $display("FAIL sub_x2: got %h expected bf800000", fadd_x2); end
        n_tests++; if (fadd_x1 !== 32'h40400000) begin n_fail++; $display("FAIL sub_x1: got %h expected 40400000", fadd_x1); end
        repeat (4) tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_result !== 32'h40000000) begin n_fail++; $display("FAIL sub_result: got %h expected 40000000", out_result); end
        n_tests++; if (out_tag !== 5'd5) begin n_fail++; $display("FAIL sub_tag: got %0d expected 5", out_tag); end
        drain();
    endtask

    task automatic test_back_to_back();
        int  issued;
        bit  acc;
        clear_sb();
        issued    = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (issued < 8 || acc_q.size() > 0); c++) begin
            if (issued < 8) begin
                if (!in_valid) set_rand_op(5'(issued));
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin issued++; in_valid = 1'b0; end
            n_tests++;
            if (in_ready !== (acc_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b expected %b", cycle, in_ready, acc_q.size() < DEPTH);
            end
            n_tests++;
            if (out_valid !== (acc_q.size() > 0 && acc_q[0] <= cycle - 4)) begin
                n_fail++; $display("FAIL b2b_out_valid: cycle %0d got %b", cycle, out_valid);
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (obs_q.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][4:0] !== 5'(i)) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int  issued;
        bit  acc;
        clear_sb();
        issued    = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (issued < 6 && !in_valid) set_rand_op(5'(10 + issued));
            acc = in_valid && in_ready;
            tick();
            if (acc) begin issued++; in_valid = 1'b0; end
        end
        n_tests++; if (issued != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", issued); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
        n_tests++;
        if (out_tag !== 5'd10 || out_result !== exp_q[0][36:5]) begin
            n_fail++; $display("FAIL bp_head_stable: got %h/%0d expected %h/10", out_result, out_tag, exp_q[0][36:5]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (issued < 6 || acc_q.size() > 0); c++) begin
            if (issued < 6 && !in_valid) set_rand_op(5'(10 + issued));
            acc = in_valid && in_ready;
            tick();
            if (acc) begin issued++; in_valid = 1'b0; end
            n_tests++;
            if (in_ready !== (acc_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL bp_credit: cycle %0d got %b expected %b", cycle, in_ready, acc_q.size() < DEPTH);
            end
        end
        n_tests++;
        if (obs_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d results expected 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][4:0] !== 5'(10 + i)) begin
                n_fail++; $display("FAIL bp_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        drain();
    endtask

    task automatic test_occ_boundary();
        int issued;
        bit acc;
        clear_sb();
        issued    = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && issued < 3; c++) begin
            if (!in_valid) set_rand_op(5'(20 + issued));
            acc = in_valid && in_ready;
            tick();
            if (acc) begin issued++; in_valid = 1'b0; end
        end
        repeat (5) tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL occ3_state: in_ready %b out_valid %b expected 1/1", in_ready, out_valid); end
        set_rand_op(5'd23);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++; if (exp_q.size() != 4 || obs_q.size() != 1) begin n_fail++; $display("FAIL occ3_both: accepts %0d pops %0d expected 4/1", exp_q.size(), obs_q.size()); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL occ3_hold: in_ready %b expected 1", in_ready); end
        set_rand_op(5'd24);
        tick();
        in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL occ_full: in_ready %b expected 0", in_ready); end
        set_rand_op(5'd25);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (exp_q.size() != 5 || obs_q.size() != 2) begin n_fail++; $display("FAIL occ_full_pop: accepts %0d pops %0d expected 5/2", exp_q.size(), obs_q.size()); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL occ_full_release: in_ready %b expected 1", in_ready); end
        drain();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL occ_result[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 37'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        clear_sb();
        out_ready = 1'b0;
        set_op(7, 8, 1'b0, 5'd1); tick();
        set_op(9, 4, 1'b1, 5'd2); tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_async: out_valid %b busy %b in_ready %b expected 0/0/1", out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        clear_sb();
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_mid_quiet: out_valid high on %0d cycles expected 0", bad); end
        out_ready = 1'b0;
        set_op(5, -7, 1'b0, 5'd9);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_result !== 32'hC0000000 || out_tag !== 5'd9) begin
            n_fail++; $display("FAIL rst_mid_result: got %h/%0d expected c0000000/9", out_result, out_tag);
        end
        drain();
    endtask

    task automatic test_random();
        bit acc;
        clear_sb();
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && $urandom_range(0, 99) < 70) set_rand_op(5'($urandom));
            out_ready = ($urandom_range(0, 99) < 60);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            n_tests++;
            if (in_ready !== (acc_q.size() < DEPTH) || busy !== (acc_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_credit: cycle %0d in_ready %b busy %b inflight %0d", cycle, in_ready, busy, acc_q.size());
            end
            n_tests++;
            if (out_valid !== (acc_q.size() > 0 && acc_q[0] <= cycle - 4)) begin
                n_fail++; $display("FAIL rnd_out_valid: cycle %0d got %b", cycle, out_valid);
            end
        end
        drain();
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_occ_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
